// File: rtl/act_pkg.sv
// Shared definitions for the activation-engine arbiter: function selects and FSM encoding.
package act_pkg;

    localparam logic [1:0] ACT_RELU     = 2'd0;
    localparam logic [1:0] ACT_LEAKY    = 2'd1;
    localparam logic [1:0] ACT_HARDTANH = 2'd2;
    localparam logic [1:0] ACT_SIGMOID  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/act_tag_fifo.sv
// Ordered tag FIFO recording which requester owns each in-flight engine sample.
module act_tag_fifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic [W-1:0]                     din,
    input  logic                             pop,
    output logic [W-1:0]                     head_c,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             empty_c
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty_c = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign head_c  = mem[rd_ptr];
    assign do_pop  = pop && !empty_c;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/act_arbiter.sv
// Round-robin scheduler sharing one activation engine among NREQ requesters,
// with in-order return of results tagged by requester id.
module act_arbiter
    import act_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned NREQ         = 4,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter int unsigned IDW          = $clog2(NREQ)
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic [NREQ-1:0]         req,
    input  logic [2*NREQ-1:0]       sel,
    input  logic [WIDTH*NREQ-1:0]   data,
    input  logic                    flush,
    output logic [NREQ-1:0]         gnt,
    output logic                    act_enable,
    output logic [1:0]              act_sel,
    output logic [WIDTH-1:0]        act_data,
    input  logic [WIDTH-1:0]        act_result,
    input  logic                    act_rdy,
    output logic [WIDTH-1:0]        dataOut,
    output logic                    res_valid,
    output logic [IDW-1:0]          res_id,
    output logic                    busy,
    output logic                    err_unexpected
);
    localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

    state_e           state;
    state_e           state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic [NREQ-1:0]  eligible;
    logic             any_elig;
    logic             issue;
    logic             pop;
    logic [IDW-1:0]   head_c;
    logic [CW-1:0]    count;
    logic             fifo_empty_c;
    int unsigned      idx;

    logic [1:0]       sel_arr  [NREQ];
    logic [WIDTH-1:0] data_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign sel_arr[i]  = sel[2*i +: 2];
        assign data_arr[i] = data[WIDTH*i +: WIDTH];
    end

    // The requester granted last cycle still shows req, so it is masked out.
    always_comb begin
        eligible = req & ~gnt;
        any_elig = |eligible;
        winner   = '0;
        idx      = 0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            idx = (32'(ptr) + k - 1) % NREQ;
            if (eligible[IDW'(idx)]) winner = IDW'(idx);
        end
    end

    assign pop = act_rdy && !fifo_empty_c;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (any_elig && !flush) state_next = RUN;
            end
            RUN: begin
                if (flush)                          state_next = DRAIN;
                else if (!any_elig && fifo_empty_c) state_next = IDLE;
            end
            DRAIN: begin
                if (fifo_empty_c && !flush) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if ((state != DRAIN) && !flush && any_elig &&
            ((count < CW'(MAX_INFLIGHT)) || act_rdy))
            issue = 1'b1;
    end

    // Issue and return pipelines; payload outputs hold between strobes.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            ptr            <= '0;
            gnt            <= '0;
            act_enable     <= 1'b0;
            act_sel        <= '0;
            act_data       <= '0;
            dataOut        <= '0;
            res_valid      <= 1'b0;
            res_id         <= '0;
            busy           <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            gnt        <= '0;
            act_enable <= issue;
            res_valid  <= pop;
            busy       <= (state_next != IDLE);
            if (issue) begin
                gnt      <= NREQ'(1) << winner;
                act_sel  <= sel_arr[winner];
                act_data <= data_arr[winner];
                ptr      <= (32'(winner) == NREQ - 1) ? '0 : winner + IDW'(1);
            end
            if (pop) begin
                dataOut <= act_result;
                res_id  <= head_c;
            end
            if (act_rdy && fifo_empty_c) err_unexpected <= 1'b1;
        end
    end

    act_tag_fifo #(
        .W     (IDW),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk     (iClk),
        .rst_n   (iRst),
        .push    (issue),
        .din     (winner),
        .pop     (pop),
        .head_c  (head_c),
        .count   (count),
        .empty_c (fifo_empty_c)
    );

endmodule

// File: doc/act_arbiter.md
Name: act_arbiter

Overview:
- Schedules one shared activation engine (relu/leakyRelu/hardtanh/sigmoid family, same data/enable/rdy style) among NREQ requesters.
- Round-robin arbitration. Issues one sample per cycle to the engine, tracks in-flight requests in an ordered tag FIFO, and routes each returned result back with its requester id.
- Sits between the per-lane feature producers and the single activation engine instance in the layer datapath.

Parameters:
- WIDTH, 8, signed sample width.
- NREQ, 4, number of requesters.
- MAX_INFLIGHT, 4, tag FIFO depth; max issued-but-unreturned samples (power of 2).
- IDW, $clog2(NREQ), requester id width.

Ports:
- iClk  in  1  clock; all state on rising edge.
- iRst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request; held with sel/data until its gnt pulse.
- sel  in  2*NREQ  per-requester function select: 0 relu, 1 leakyRelu, 2 hardtanh, 3 sigmoid.
- data  in  WIDTH*NREQ  per-requester signed sample.
- flush  in  1  stop granting and drain in-flight work.
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted.
- act_enable  out  1  issue strobe to engine.
- act_sel  out  2  function select to engine.
- act_data  out  WIDTH  sample to engine.
- act_result  in  WIDTH  engine result.
- act_rdy  in  1  engine result valid; results return in issue order.
- dataOut  out  WIDTH  returned result.
- res_valid  out  1  dataOut/res_id valid, one cycle.
- res_id  out  IDW  requester that owns dataOut.
- busy  out  1  state != IDLE.
- err_unexpected  out  1  sticky: act_rdy seen with empty tag FIFO.

Behaviour:
- Reset (iRst=0, async): all outputs 0, RR pointer 0, FIFO empty, state IDLE, err_unexpected cleared. Reset mid-operation discards all in-flight tags. Results arriving after reset release with an empty FIFO set err_unexpected.
- FSM:
  - IDLE -> RUN on any eligible req and flush=0.
  - RUN -> DRAIN on flush=1.
  - RUN -> IDLE when no eligible req and FIFO empty.
  - DRAIN: no grants. -> IDLE when FIFO empty and flush=0. Stays in DRAIN while flush=1.
- Eligibility: req[i]=1 and gnt[i]=0 in the current cycle. This masks the requester granted last cycle whose req is still visible.
- Issue condition: state RUN (or IDLE transitioning to RUN in the same cycle), eligible req exists, and (count < MAX_INFLIGHT or act_rdy=1 this cycle). A simultaneous pop frees the slot.
- Arbitration: winner is the first eligible index searching from ptr upward, modulo NREQ. After a grant, ptr = winner+1 mod NREQ. ptr is unchanged when there is no grant.
- Issue timing: req sampled in cycle N. At edge N+1, registered outputs go high for exactly one cycle: gnt[w]=1, act_enable=1, act_sel=sel[w], act_data=data[w]. Tag w is pushed to the FIFO at the same edge.
- Return: act_rdy=1 in cycle M pops the FIFO head. At edge M+1: res_valid=1, dataOut=act_result, res_id=head. Fixed latency of 1 cycle. Back-to-back act_rdy gives back-to-back results.
- Simultaneous push and pop: count unchanged, both performed.
- act_rdy with FIFO empty: result dropped, res_valid stays 0, err_unexpected=1 until reset.
- Outputs other than the strobes hold their last value when res_valid/act_enable=0.
- FIFO pointers are log2(MAX_INFLIGHT) bits and wrap naturally. count is log2(MAX_INFLIGHT)+1 bits.

Decomposition:
- Shared package act_pkg: function-select constants (ACT_RELU=0, ACT_LEAKY=1, ACT_HARDTANH=2, ACT_SIGMOID=3) and the FSM state encoding (IDLE, RUN, DRAIN).
- One sub-module: act_tag_fifo (width IDW, depth MAX_INFLIGHT, push/pop/count/empty/full, same-cycle push+pop).
- RR arbiter logic stays inline.

Test Plan:
- Single request: req[2]=1, sel=0, data=-5. Expect gnt[2] one cycle later, act_enable=1, act_data=-5. Model engine returns 0 after 1 cycle; expect res_valid=1, res_id=2, dataOut=0.
- All four req held continuously. Expect grants in order 0,1,2,3,0,... on consecutive issue slots. No requester granted twice in two adjacent cycles.
- Engine stalls (act_rdy=0) while requests continue. Expect exactly 4 grants, then none. One act_rdy re-enables exactly one grant in that same cycle's decision.
- Engine latency 3, mixed sel, data -128..127 from requesters 1 and 3 alternating. Expect res_id sequence to match issue order and dataOut to match the engine model.
- flush=1 with 3 in flight. Expect no gnt, 3 results delivered, busy=1 until the FIFO is empty, then IDLE with busy=0 one cycle after flush=0.
- act_rdy pulse with empty FIFO: expect err_unexpected=1, res_valid=0. Async iRst=0 mid-stream: all outputs immediately 0.
